// File: rtl/qua_lsp_sequencer_pkg.sv
// Shared constants for the LSP stage sequencer: stage count, slice widths and FSM encodings.
package qua_lsp_sequencer_pkg;

    localparam int NumStages = 4;
    localparam int AddrW     = 12;
    localparam int DataW     = 32;
    localparam int OpW       = 16;
    localparam int LShrW     = 32;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLaunch = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    // Returns {found, index} of the lowest set mask bit at or above floor.
    function automatic logic [2:0] lowest_from(input logic [3:0] mask, input logic [2:0] floor);
        logic [2:0] r;
        r = '0;
        for (int i = NumStages - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(floor))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qua_lsp_req_mux.sv
// Combinational router: selects the granted stage's requests onto the shared buses, or zero.
module qua_lsp_req_mux
    import qua_lsp_sequencer_pkg::*;
(
    input  logic [1:0]               sel,
    input  logic                     gate,
    input  logic [AddrW*NumStages-1:0] stgMemReadAddr,
    input  logic [AddrW*NumStages-1:0] stgMemWriteAddr,
    input  logic [AddrW*NumStages-1:0] stgConstantMemAddr,
    input  logic [DataW*NumStages-1:0] stgMemOut,
    input  logic [NumStages-1:0]     stgMemWriteEn,
    input  logic [OpW*NumStages-1:0] stgMultA,
    input  logic [OpW*NumStages-1:0] stgMultB,
    input  logic [OpW*NumStages-1:0] stgAddA,
    input  logic [OpW*NumStages-1:0] stgAddB,
    input  logic [OpW*NumStages-1:0] stgSubA,
    input  logic [OpW*NumStages-1:0] stgSubB,
    input  logic [OpW*NumStages-1:0] stgLMultA,
    input  logic [OpW*NumStages-1:0] stgLMultB,
    input  logic [OpW*NumStages-1:0] stgShrVar1,
    input  logic [OpW*NumStages-1:0] stgShrVar2,
    input  logic [OpW*NumStages-1:0] stgLShrNumShift,
    input  logic [LShrW*NumStages-1:0] stgLShrVar1,
    output logic [AddrW-1:0]         memReadAddr,
    output logic [AddrW-1:0]         memWriteAddr,
    output logic [AddrW-1:0]         constantMemAddr,
    output logic [DataW-1:0]         memOut,
    output logic                     memWriteEn,
    output logic [OpW-1:0]           multOutA,
    output logic [OpW-1:0]           multOutB,
    output logic [OpW-1:0]           addOutA,
    output logic [OpW-1:0]           addOutB,
    output logic [OpW-1:0]           subOutA,
    output logic [OpW-1:0]           subOutB,
    output logic [OpW-1:0]           L_multOutA,
    output logic [OpW-1:0]           L_multOutB,
    output logic [OpW-1:0]           shrVar1Out,
    output logic [OpW-1:0]           shrVar2Out,
    output logic [OpW-1:0]           L_shrNumShiftOut,
    output logic [LShrW-1:0]         L_shrVar1Out
);

    int s;

    always_comb begin
        s                = int'(sel);
        memReadAddr      = '0;
        memWriteAddr     = '0;
        constantMemAddr  = '0;
        memOut           = '0;
        memWriteEn       = 1'b0;
        multOutA         = '0;
        multOutB         = '0;
        addOutA          = '0;
        addOutB          = '0;
        subOutA          = '0;
        subOutB          = '0;
        L_multOutA       = '0;
        L_multOutB       = '0;
        shrVar1Out       = '0;
        shrVar2Out       = '0;
        L_shrNumShiftOut = '0;
        L_shrVar1Out     = '0;
        if (gate) begin
            memReadAddr      = stgMemReadAddr[s*AddrW +: AddrW];
            memWriteAddr     = stgMemWriteAddr[s*AddrW +: AddrW];
            constantMemAddr  = stgConstantMemAddr[s*AddrW +: AddrW];
            memOut           = stgMemOut[s*DataW +: DataW];
            memWriteEn       = stgMemWriteEn[s];
            multOutA         = stgMultA[s*OpW +: OpW];
            multOutB         = stgMultB[s*OpW +: OpW];
            addOutA          = stgAddA[s*OpW +: OpW];
            addOutB          = stgAddB[s*OpW +: OpW];
            subOutA          = stgSubA[s*OpW +: OpW];
            subOutB          = stgSubB[s*OpW +: OpW];
            L_multOutA       = stgLMultA[s*OpW +: OpW];
            L_multOutB       = stgLMultB[s*OpW +: OpW];
            shrVar1Out       = stgShrVar1[s*OpW +: OpW];
            shrVar2Out       = stgShrVar2[s*OpW +: OpW];
            L_shrNumShiftOut = stgLShrNumShift[s*OpW +: OpW];
            L_shrVar1Out     = stgLShrVar1[s*LShrW +: LShrW];
        end
    end

endmodule

// File: rtl/qua_lsp_sequencer.sv
// Runs the enabled LSP stage sub-FSMs one at a time in ascending order and routes the
// granted stage's memory/operator requests onto the shared buses.
module qua_lsp_sequencer
    import qua_lsp_sequencer_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   stageEnable,
    input  logic [3:0]   stageDone,
    input  logic [47:0]  stgMemReadAddr,
    input  logic [47:0]  stgMemWriteAddr,
    input  logic [47:0]  stgConstantMemAddr,
    input  logic [127:0] stgMemOut,
    input  logic [3:0]   stgMemWriteEn,
    input  logic [63:0]  stgMultA,
    input  logic [63:0]  stgMultB,
    input  logic [63:0]  stgAddA,
    input  logic [63:0]  stgAddB,
    input  logic [63:0]  stgSubA,
    input  logic [63:0]  stgSubB,
    input  logic [63:0]  stgLMultA,
    input  logic [63:0]  stgLMultB,
    input  logic [63:0]  stgShrVar1,
    input  logic [63:0]  stgShrVar2,
    input  logic [63:0]  stgLShrNumShift,
    input  logic [127:0] stgLShrVar1,
    output logic [3:0]   stageStart,
    output logic [11:0]  memReadAddr,
    output logic [11:0]  memWriteAddr,
    output logic [11:0]  constantMemAddr,
    output logic [31:0]  memOut,
    output logic         memWriteEn,
    output logic [15:0]  multOutA,
    output logic [15:0]  multOutB,
    output logic [15:0]  addOutA,
    output logic [15:0]  addOutB,
    output logic [15:0]  subOutA,
    output logic [15:0]  subOutB,
    output logic [15:0]  L_multOutA,
    output logic [15:0]  L_multOutB,
    output logic [15:0]  shrVar1Out,
    output logic [15:0]  shrVar2Out,
    output logic [15:0]  L_shrNumShiftOut,
    output logic [31:0]  L_shrVar1Out,
    output logic [1:0]   curStage,
    output logic         busy,
    output logic         done
);

    logic [1:0] state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic [3:0] en_q, en_d;
    logic [2:0] first_pick, next_pick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            stage_q <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            en_q    <= en_d;
        end
    end

    assign first_pick = lowest_from(stageEnable, 3'd0);
    assign next_pick  = lowest_from(en_q, {1'b0, stage_q} + 3'd1);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        en_d    = en_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    en_d = stageEnable;
                    if (first_pick[2]) begin
                        state_d = StLaunch;
                        stage_d = first_pick[1:0];
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                // Only the granted stage's done bit can advance the sequence.
                if (stageDone[stage_q]) begin
                    if (next_pick[2]) begin
                        state_d = StLaunch;
                        stage_d = next_pick[1:0];
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        stageStart = '0;
        if (state_q == StLaunch) begin
            stageStart[stage_q] = 1'b1;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFinish);
    assign curStage = stage_q;

    qua_lsp_req_mux u_req_mux (
        .sel                (stage_q),
        .gate               ((state_q == StLaunch) || (state_q == StWait)),
        .stgMemReadAddr     (stgMemReadAddr),
        .stgMemWriteAddr    (stgMemWriteAddr),
        .stgConstantMemAddr (stgConstantMemAddr),
        .stgMemOut          (stgMemOut),
        .stgMemWriteEn      (stgMemWriteEn),
        .stgMultA           (stgMultA),
        .stgMultB           (stgMultB),
        .stgAddA            (stgAddA),
        .stgAddB            (stgAddB),
        .stgSubA            (stgSubA),
        .stgSubB            (stgSubB),
        .stgLMultA          (stgLMultA),
        .stgLMultB          (stgLMultB),
        .stgShrVar1         (stgShrVar1),
        .stgShrVar2         (stgShrVar2),
        .stgLShrNumShift    (stgLShrNumShift),
        .stgLShrVar1        (stgLShrVar1),
        .memReadAddr        (memReadAddr),
        .memWriteAddr       (memWriteAddr),
        .constantMemAddr    (constantMemAddr),
        .memOut             (memOut),
        .memWriteEn         (memWriteEn),
        .multOutA           (multOutA),
        .multOutB           (multOutB),
        .addOutA            (addOutA),
        .addOutB            (addOutB),
        .subOutA            (subOutA),
        .subOutB            (subOutB),
        .L_multOutA         (L_multOutA),
        .L_multOutB         (L_multOutB),
        .shrVar1Out         (shrVar1Out),
        .shrVar2Out         (shrVar2Out),
        .L_shrNumShiftOut   (L_shrNumShiftOut),
        .L_shrVar1Out       (L_shrVar1Out)
    );

endmodule

// File: tb/tb_qua_lsp_sequencer.sv
// Scoreboard bench: the stimulus driver pushes expected start/done events with their cycle,
// a negedge monitor pops and compares them against what the sequencer presents.
module tb_qua_lsp_sequencer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   stageEnable = '0;
    logic [3:0]   stageDone = '0;
    logic [47:0]  rd_bus = '0, wr_bus = '0, cm_bus = '0;
    logic [127:0] mo_bus = '0, ls1_bus = '0;
    logic [3:0]   we_bus = '0;
    logic [63:0]  op_bus [11];
    logic [3:0]   stageStart;
    logic [11:0]  memReadAddr, memWriteAddr, constantMemAddr;
    logic [31:0]  memOut, L_shrVar1Out;
    logic         memWriteEn, busy, done;
    logic [15:0]  op_out [11];
    logic [1:0]   curStage;

    typedef struct {
        logic       is_done;
        logic [1:0] stage;
        int         cyc;
        logic [1:0] cur;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] last_granted = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qua_lsp_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .stageEnable        (stageEnable),
        .stageDone          (stageDone),
        .stgMemReadAddr     (rd_bus),
        .stgMemWriteAddr    (wr_bus),
        .stgConstantMemAddr (cm_bus),
        .stgMemOut          (mo_bus),
        .stgMemWriteEn      (we_bus),
        .stgMultA           (op_bus[0]),
        .stgMultB           (op_bus[1]),
        .stgAddA            (op_bus[2]),
        .stgAddB            (op_bus[3]),
        .stgSubA            (op_bus[4]),
        .stgSubB            (op_bus[5]),
        .stgLMultA          (op_bus[6]),
        .stgLMultB          (op_bus[7]),
        .stgShrVar1         (op_bus[8]),
        .stgShrVar2         (op_bus[9]),
        .stgLShrNumShift    (op_bus[10]),
        .stgLShrVar1        (ls1_bus),
        .stageStart         (stageStart),
        .memReadAddr        (memReadAddr),
        .memWriteAddr       (memWriteAddr),
        .constantMemAddr    (constantMemAddr),
        .memOut             (memOut),
        .memWriteEn         (memWriteEn),
        .multOutA           (op_out[0]),
        .multOutB           (op_out[1]),
        .addOutA            (op_out[2]),
        .addOutB            (op_out[3]),
        .subOutA            (op_out[4]),
        .subOutB            (op_out[5]),
        .L_multOutA         (op_out[6]),
        .L_multOutB         (op_out[7]),
        .shrVar1Out         (op_out[8]),
        .shrVar2Out         (op_out[9]),
        .L_shrNumShiftOut   (op_out[10]),
        .L_shrVar1Out       (L_shrVar1Out),
        .curStage           (curStage),
        .busy               (busy),
        .done               (done)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic any_shared();
        logic r;
        r = |{memReadAddr, memWriteAddr, constantMemAddr, memOut, memWriteEn, L_shrVar1Out};
        for (int j = 0; j < 11; j++) r = r | (|op_out[j]);
        return r;
    endfunction

    // Monitor: every start pulse or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (stageStart != 4'b0 || done)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {59'b0, done, stageStart}, 64'h0);
            end else begin
                ev_t e;
                int  k;
                e = exp_q.pop_front();
                k = int'(e.stage);
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                chk("cur_stage", 64'(curStage), 64'(e.cur));
                chk("busy_at_event", 64'(busy), 64'h1);
                if (e.is_done) begin
                    chk("done_pulse", {59'b0, done, stageStart}, {59'b0, 1'b1, 4'b0});
                    chk("shared_zero_at_done", 64'(any_shared()), 64'h0);
                end else begin
                    chk("stage_start", {59'b0, done, stageStart}, {59'b0, 1'b0, 4'b1 << k});
                    chk("mem_read_addr", 64'(memReadAddr), 64'(rd_bus[k*12 +: 12]));
                    chk("mem_write_addr", 64'(memWriteAddr), 64'(wr_bus[k*12 +: 12]));
                    chk("const_mem_addr", 64'(constantMemAddr), 64'(cm_bus[k*12 +: 12]));
                    chk("mem_out", 64'(memOut), 64'(mo_bus[k*32 +: 32]));
                    chk("mem_write_en", 64'(memWriteEn), 64'(we_bus[k]));
                    chk("l_shr_var1", 64'(L_shrVar1Out), 64'(ls1_bus[k*32 +: 32]));
                    for (int j = 0; j < 11; j++) begin
                        chk($sformatf("operand_%0d", j), 64'(op_out[j]), 64'(op_bus[j][k*16 +: 16]));
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cyc > 40000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 40000", cyc);
            $fatal(1);
        end
    end

    task automatic randomize_buses();
        rd_bus  = {$urandom, $urandom};
        wr_bus  = {$urandom, $urandom};
        cm_bus  = {$urandom, $urandom};
        mo_bus  = {$urandom, $urandom, $urandom, $urandom};
        ls1_bus = {$urandom, $urandom, $urandom, $urandom};
        we_bus  = 4'($urandom);
        for (int j = 0; j < 11; j++) op_bus[j] = {$urandom, $urandom};
    endtask

    // One run: expected events follow from the mask alone (ascending set bits, then done).
    task automatic do_run(input logic [3:0] mask, input int fixed_d, input logic keep_bus);
        int order[$];
        int d;
        ev_t e;
        if (!keep_bus) randomize_buses();
        for (int i = 0; i < 4; i++) if (mask[i]) order.push_back(i);
        @(posedge clk); #1;
        start = 1'b1;
        stageEnable = mask;
        if (order.size() == 0) e = '{is_done: 1'b1, stage: 2'd0, cyc: cyc + 1, cur: last_granted};
        else e = '{is_done: 1'b0, stage: 2'(order[0]), cyc: cyc + 1, cur: 2'(order[0])};
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        stageEnable = 4'($urandom);
        for (int n = 0; n < order.size(); n++) begin
            int k;
            k = order[n];
            d = (fixed_d != 0) ? fixed_d : int'($urandom_range(1, 5));
            repeat (d) begin
                @(posedge clk); #1;
                stageDone = 4'($urandom) & ~(4'b1 << k);
                start = 1'($urandom);
                stageEnable = 4'($urandom);
            end
            stageDone = stageDone | (4'b1 << k);
            last_granted = 2'(k);
            if (n + 1 < order.size())
                e = '{is_done: 1'b0, stage: 2'(order[n+1]), cyc: cyc + 1, cur: 2'(order[n+1])};
            else
                e = '{is_done: 1'b1, stage: 2'd0, cyc: cyc + 1, cur: 2'(k)};
            exp_q.push_back(e);
            @(posedge clk); #1;
            stageDone = '0;
            start = 1'b0;
        end
        @(posedge clk); #1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int j = 0; j < 11; j++) op_bus[j] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_stage_start", 64'(stageStart), 64'h0);
        chk("reset_cur_stage", 64'(curStage), 64'h0);
        chk("reset_shared_zero", 64'(any_shared()), 64'h0);
        reset = 1'b0;

        do_run(4'b1111, 5, 1'b0);
        do_run(4'b1010, 0, 1'b0);
        do_run(4'b0000, 0, 1'b0);

        randomize_buses();
        rd_bus = {12'hFFF, 12'h2A5, 12'hFFF, 12'hFFF};
        do_run(4'b0100, 3, 1'b1);
        chk("idle_mem_read_addr", 64'(memReadAddr), 64'h0);
        chk("idle_busy", 64'(busy), 64'h0);

        // Abandon a run while stage 1 is waiting, then start afresh.
        randomize_buses();
        @(posedge clk); #1;
        start = 1'b1;
        stageEnable = 4'b0110;
        exp_q.push_back('{is_done: 1'b0, stage: 2'd1, cyc: cyc + 1, cur: 2'd1});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrun_reset_busy", 64'(busy), 64'h0);
        chk("midrun_reset_done", 64'(done), 64'h0);
        chk("midrun_reset_start", 64'(stageStart), 64'h0);
        chk("midrun_reset_cur", 64'(curStage), 64'h0);
        chk("midrun_reset_shared", 64'(any_shared()), 64'h0);
        chk("midrun_reset_pending", 64'(exp_q.size()), 64'h0);
        exp_q.delete();
        last_granted = 2'd0;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        do_run(4'b0110, 0, 1'b0);

        for (int r = 0; r < 30; r++) do_run(4'($urandom), 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
